// File: rtl/fruit_spawner.sv
// Fruit placement engine: draws random grid candidates, checks them against the
// snake via an occupancy query, and falls back to a linear scan after MAX_TRIES rejects.
module fruit_spawner #(
  parameter int COORD_W   = 3,
  parameter int GRID_W    = 8,
  parameter int GRID_H    = 8,
  parameter int MAX_TRIES = 8,
  parameter int INIT_X    = 0,
  parameter int INIT_Y    = 5
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_spawn_req,
  input  logic [2*COORD_W-1:0] i_random,
  output logic                 o_query_valid,
  output logic [COORD_W-1:0]   o_query_x,
  output logic [COORD_W-1:0]   o_query_y,
  input  logic                 i_resp_valid,
  input  logic                 i_resp_occupied,
  output logic [COORD_W-1:0]   o_fruit_x,
  output logic [COORD_W-1:0]   o_fruit_y,
  output logic                 o_fruit_valid,
  output logic                 o_board_full,
  output logic                 o_busy
);

  localparam int RW = 2 * COORD_W;
  localparam int GW = $clog2(RW + 1);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam int SW = $clog2(GRID_W * GRID_H + 1);

  typedef enum logic [2:0] {
    IDLE, GAP, CHECK, WAIT_R, SCAN_Q, SCAN_R, COMMIT, FULL
  } state_t;

  state_t             state, state_nxt;
  logic [GW-1:0]      gap_cnt;
  logic [TW-1:0]      tries;
  logic [SW-1:0]      scan_cnt;
  logic [COORD_W-1:0] cand_x, cand_y;
  logic [COORD_W-1:0] fruit_x, fruit_y;

  logic               off_grid, tries_last, scan_last, gap_done, reject;
  logic [COORD_W-1:0] wrap_x, wrap_y, adv_x, adv_y;

  always_comb begin
    off_grid   = (int'(cand_x) >= GRID_W) || (int'(cand_y) >= GRID_H);
    tries_last = (tries == TW'(MAX_TRIES - 1));
    scan_last  = (scan_cnt == SW'(GRID_W * GRID_H - 1));
    gap_done   = (gap_cnt == GW'(RW));
    reject     = ((state == CHECK) && off_grid) ||
                 ((state == WAIT_R) && i_resp_valid && i_resp_occupied);
    wrap_x     = COORD_W'(int'(cand_x) % GRID_W);
    wrap_y     = COORD_W'(int'(cand_y) % GRID_H);
    adv_x      = cand_x + COORD_W'(1);
    adv_y      = cand_y;
    if (int'(cand_x) == GRID_W - 1) begin
      adv_x = '0;
      adv_y = (int'(cand_y) == GRID_H - 1) ? '0 : cand_y + COORD_W'(1);
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_spawn_req) state_nxt = GAP;
      GAP:     if (gap_done) state_nxt = CHECK;
      CHECK:   state_nxt = off_grid ? (tries_last ? SCAN_Q : GAP) : WAIT_R;
      WAIT_R:  if (i_resp_valid)
                 state_nxt = i_resp_occupied ? (tries_last ? SCAN_Q : GAP) : COMMIT;
      SCAN_Q:  state_nxt = SCAN_R;
      SCAN_R:  if (i_resp_valid)
                 state_nxt = i_resp_occupied ? (scan_last ? FULL : SCAN_Q) : COMMIT;
      COMMIT:  state_nxt = IDLE;
      FULL:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_query_valid = ((state == CHECK) && !off_grid) || (state == SCAN_Q);
    o_fruit_valid = (state == COMMIT);
    o_board_full  = (state == FULL);
    o_busy        = (state != IDLE);
  end

  // Candidate register doubles as the scan cursor; every reject reloads it wrapped
  // into the grid, so the scan entry point is ready whichever reject was the last.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      gap_cnt  <= '0;
      tries    <= '0;
      scan_cnt <= '0;
      cand_x   <= '0;
      cand_y   <= '0;
      fruit_x  <= COORD_W'(INIT_X);
      fruit_y  <= COORD_W'(INIT_Y);
    end else begin
      case (state)
        IDLE: if (i_spawn_req) begin
          gap_cnt  <= '0;
          tries    <= '0;
          scan_cnt <= '0;
        end
        GAP: begin
          if (gap_done) begin
            cand_x <= i_random[COORD_W-1:0];
            cand_y <= i_random[2*COORD_W-1:COORD_W];
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        SCAN_R: if (i_resp_valid && i_resp_occupied) begin
          cand_x   <= adv_x;
          cand_y   <= adv_y;
          scan_cnt <= scan_cnt + SW'(1);
        end
        COMMIT: begin
          fruit_x <= cand_x;
          fruit_y <= cand_y;
        end
        default: ;
      endcase
      if (reject) begin
        tries   <= tries + TW'(1);
        gap_cnt <= '0;
        cand_x  <= wrap_x;
        cand_y  <= wrap_y;
      end
    end
  end

  assign o_query_x = cand_x;
  assign o_query_y = cand_y;
  assign o_fruit_x = fruit_x;
  assign o_fruit_y = fruit_y;

endmodule

// File: tb/tb_fruit_spawner.sv
// Directed bench for fruit_spawner: an 8x8 instance and a 5-wide instance, each
// with a scripted occupancy responder answering one cycle after every query.
module tb_fruit_spawner;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // instance A: 8x8
  logic       req_a = 0, stray_a = 0, occ_a = 0, silent_a = 0, resp_drv_a = 0;
  logic [5:0] rnd_a = '0;
  logic       qv_a, resp_valid_a, fv_a, bf_a, busy_a;
  logic [2:0] qx_a, qy_a, fx_a, fy_a;
  assign resp_valid_a = resp_drv_a | stray_a;

  fruit_spawner #(.COORD_W(3), .GRID_W(8), .GRID_H(8), .MAX_TRIES(8), .INIT_X(0), .INIT_Y(5)) dut_a (
    .i_clock(clk), .i_reset_n(rst_n), .i_spawn_req(req_a), .i_random(rnd_a),
    .o_query_valid(qv_a), .o_query_x(qx_a), .o_query_y(qy_a),
    .i_resp_valid(resp_valid_a), .i_resp_occupied(occ_a),
    .o_fruit_x(fx_a), .o_fruit_y(fy_a), .o_fruit_valid(fv_a),
    .o_board_full(bf_a), .o_busy(busy_a)
  );

  // instance B: 5 wide, 8 high
  logic       req_b = 0, resp_drv_b = 0;
  logic [5:0] rnd_b = '0;
  logic       qv_b, fv_b, bf_b, busy_b;
  logic [2:0] qx_b, qy_b, fx_b, fy_b;

  fruit_spawner #(.COORD_W(3), .GRID_W(5), .GRID_H(8), .MAX_TRIES(8), .INIT_X(0), .INIT_Y(5)) dut_b (
    .i_clock(clk), .i_reset_n(rst_n), .i_spawn_req(req_b), .i_random(rnd_b),
    .o_query_valid(qv_b), .o_query_x(qx_b), .o_query_y(qy_b),
    .i_resp_valid(resp_drv_b), .i_resp_occupied(1'b1),
    .o_fruit_x(fx_b), .o_fruit_y(fy_b), .o_fruit_valid(fv_b),
    .o_board_full(bf_b), .o_busy(busy_b)
  );

  logic [5:0] qlog_a[$];
  logic [5:0] qlog_b[$];
  int nfv_a = 0, nbf_a = 0, fv_cyc_a = 0, nfv_b = 0, nbf_b = 0;

  always @(negedge clk) begin
    if (qv_a) qlog_a.push_back({qy_a, qx_a});
    if (qv_b) qlog_b.push_back({qy_b, qx_b});
    if (fv_a) begin nfv_a++; fv_cyc_a = cyc; end
    if (bf_a) nbf_a++;
    if (fv_b) nfv_b++;
    if (bf_b) nbf_b++;
  end

  initial forever begin
    @(negedge clk);
    if (qv_a && !silent_a) begin
      @(posedge clk); #1 resp_drv_a = 1'b1;
      @(posedge clk); #1 resp_drv_a = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (qv_b) begin
      @(posedge clk); #1 resp_drv_b = 1'b1;
      @(posedge clk); #1 resp_drv_b = 1'b0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [5:0] rnd;
    int         ex;
    int         ey;
    int         lat;
  } vec_t;

  vec_t vecs[4];
  int   n0, q0, req_cyc;

  initial begin
    vecs[0] = '{rnd: 6'b011_010, ex: 2, ey: 3, lat: 10};
    vecs[1] = '{rnd: 6'b000_000, ex: 0, ey: 0, lat: 10};
    vecs[2] = '{rnd: 6'b111_111, ex: 7, ey: 7, lat: 10};
    vecs[3] = '{rnd: 6'b101_100, ex: 4, ey: 5, lat: 10};

    // reset state
    #12;
    check("reset_fruit_x", int'(fx_a), 0);
    check("reset_fruit_y", int'(fy_a), 5);
    check("reset_busy", int'(busy_a), 0);
    check("reset_pulses", int'({qv_a, fv_a, bf_a}), 0);
    check("reset_query_xy", int'({qx_a, qy_a}), 0);
    check("reset_b_fruit", int'({fx_b, fy_b}), 5);
    @(posedge clk); #1 rst_n = 1'b1;
    tick(20);
    check("idle_fruit", int'({fx_a, fy_a}), 5);
    check("idle_busy", int'(busy_a), 0);
    check("idle_no_query", qlog_a.size(), 0);
    check("idle_no_fv", nfv_a, 0);

    // random draw accepted first time
    for (int i = 0; i < 4; i++) begin
      rnd_a = vecs[i].rnd;
      occ_a = 1'b0;
      n0 = nfv_a;
      q0 = qlog_a.size();
      req_a = 1'b1; req_cyc = cyc;
      tick(1);
      req_a = 1'b0;
      for (int k = 0; k < 100 && nfv_a == n0; k++) @(negedge clk);
      check($sformatf("vec%0d_fv_count", i), nfv_a - n0, 1);
      check($sformatf("vec%0d_latency", i), fv_cyc_a - req_cyc, vecs[i].lat);
      check($sformatf("vec%0d_queries", i), qlog_a.size() - q0, 1);
      if (qlog_a.size() > q0)
        check($sformatf("vec%0d_query_xy", i), int'(qlog_a[q0]), vecs[i].ey * 8 + vecs[i].ex);
      check($sformatf("vec%0d_fruit", i), int'({fy_a, fx_a}), vecs[i].ey * 8 + vecs[i].ex);
      tick(3);
    end

    // repeated request and stray response while busy
    rnd_a = 6'b011_010;
    n0 = nfv_a;
    req_a = 1'b1; tick(1); req_a = 1'b0;
    tick(2);
    occ_a = 1'b1; stray_a = 1'b1; tick(1); stray_a = 1'b0; occ_a = 1'b0;
    req_a = 1'b1; tick(1); req_a = 1'b0;
    tick(40);
    check("busy_req_fv_count", nfv_a - n0, 1);
    check("busy_req_fruit", int'({fy_a, fx_a}), 3 * 8 + 2);
    check("busy_req_idle", int'(busy_a), 0);

    // every cell occupied on 8x8
    rnd_a = 6'b011_010;
    occ_a = 1'b1;
    n0 = nfv_a;
    q0 = qlog_a.size();
    req_a = 1'b1; tick(1); req_a = 1'b0;
    for (int k = 0; k < 2000 && nbf_a == 0; k++) @(negedge clk);
    tick(2);
    check("full_pulse", nbf_a, 1);
    check("full_total_queries", qlog_a.size() - q0, 72);
    if (qlog_a.size() > q0 + 8)
      check("full_scan_start", int'(qlog_a[q0 + 8]), 3 * 8 + 2);
    if (qlog_a.size() > q0 + 9)
      check("full_scan_second", int'(qlog_a[q0 + 9]), 3 * 8 + 3);
    check("full_fruit_kept", int'({fy_a, fx_a}), 3 * 8 + 2);
    check("full_no_fv", nfv_a - n0, 0);
    check("full_idle", int'(busy_a), 0);
    occ_a = 1'b0;

    // off-grid draws on the 5-wide instance, then wrapped scan
    rnd_b = 6'b001_111;
    req_b = 1'b1; tick(1); req_b = 1'b0;
    for (int k = 0; k < 3000 && nbf_b == 0; k++) @(negedge clk);
    tick(2);
    check("w5_full_pulse", nbf_b, 1);
    check("w5_query_count", qlog_b.size(), 40);
    if (qlog_b.size() >= 4) begin
      check("w5_scan0", int'(qlog_b[0]), 1 * 8 + 2);
      check("w5_scan1", int'(qlog_b[1]), 1 * 8 + 3);
      check("w5_scan2", int'(qlog_b[2]), 1 * 8 + 4);
      check("w5_scan3", int'(qlog_b[3]), 2 * 8 + 0);
    end
    check("w5_fruit_kept", int'({fy_b, fx_b}), 5 * 8 + 0);
    check("w5_no_fv", nfv_b, 0);

    // reset while waiting for a response
    silent_a = 1'b1;
    rnd_a = 6'b110_001;
    n0 = nfv_a;
    q0 = qlog_a.size();
    req_a = 1'b1; tick(1); req_a = 1'b0;
    for (int k = 0; k < 100 && qlog_a.size() == q0; k++) @(negedge clk);
    check("rst_query_seen", qlog_a.size() - q0, 1);
    tick(1);
    rst_n = 1'b0;
    #1;
    check("rst_busy", int'(busy_a), 0);
    check("rst_fruit", int'({fy_a, fx_a}), 5 * 8 + 0);
    check("rst_fv", int'(fv_a), 0);
    silent_a = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(20);
    check("rst_no_fv_after", nfv_a - n0, 0);
    check("rst_idle_after", int'(busy_a), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
